// File: rtl/synchronizer_pkg.sv
// Shared constants and the realignment state encoding for the synchronizer.
package synchronizer_pkg;

  localparam int SLOT  = 66;
  localparam int ITERS = 64;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_ITER  = 2'd2,
    S_STORE = 2'd3
  } sync_state_e;

endpackage

// File: rtl/synchronizer_rem64_serial.sv
// Serial restoring remainder: 64-bit dividend mod WIDTH-bit divisor, one
// dividend bit per cycle, MSB first.
module rem64_serial
  import synchronizer_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [63:0]      i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_done,
  output logic [WIDTH-1:0] o_rem
);

  // Handshake: i_start is a one-cycle pulse that captures the operands; o_done
  // is high for exactly one cycle, 65 cycles after the start cycle, with o_rem
  // valid in that cycle. A new i_start aborts any run still in flight.
  logic             r_active;
  logic             r_done;
  logic [6:0]       r_cnt;
  logic [63:0]      r_dividend;
  logic [WIDTH-1:0] r_divisor;
  logic [WIDTH-1:0] r_rem;

  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  assign w_shift = {r_rem, r_dividend[63]};
  assign w_diff  = w_shift - {1'b0, r_divisor};
  // A borrow out of the top bit means the divisor did not fit.
  assign w_fits  = ~w_diff[WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active   <= 1'b0;
      r_done     <= 1'b0;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_rem      <= '0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_active   <= 1'b1;
        r_cnt      <= '0;
        r_dividend <= i_dividend;
        r_divisor  <= i_divisor;
        r_rem      <= '0;
      end else if (r_active) begin
        r_rem      <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
        r_dividend <= {r_dividend[62:0], 1'b0};
        r_cnt      <= r_cnt + 7'd1;
        if (r_cnt == 7'(ITERS - 1)) begin
          r_active <= 1'b0;
          r_done   <= 1'b1;
        end
      end
    end
  end

  assign o_done = r_done;
  assign o_rem  = r_rem;

endmodule

// File: rtl/synchronizer.sv
// Local system time plus per-transducer phase counters, realigned serially to
// a controller sync time one transducer per 66-cycle slot.
module synchronizer
  import synchronizer_pkg::*;
#(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [63:0]            ECAT_SYNC_TIME,
  input  logic                   SYNC_SET,
  input  logic [WIDTH*DEPTH-1:0] CYCLE,
  output logic [63:0]            SYS_TIME,
  output logic [WIDTH*DEPTH-1:0] TIME_CNT,
  output logic                   SYNC_BUSY,
  output logic [1:0]             o_dbg_state
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sync_state_e      r_state;
  sync_state_e      w_next_state;
  logic [IW-1:0]    r_idx;
  logic [63:0]      r_dividend;
  logic [6:0]       r_iter;
  logic             r_small;
  logic [63:0]      r_sys_time;
  logic             r_busy;

  logic [WIDTH-1:0] w_cur_cycle;
  logic             w_start;
  logic             w_done;
  logic [WIDTH-1:0] w_rem;
  logic             w_last_idx;
  logic             w_store;

  assign w_cur_cycle = CYCLE[int'(r_idx)*WIDTH +: WIDTH];
  assign w_start     = (r_state == S_LOAD);
  assign w_last_idx  = (r_idx == IW'(DEPTH - 1));
  // A sync request on the store edge restarts instead of storing a stale value.
  assign w_store     = (r_state == S_STORE) && w_done && !SYNC_SET;

  rem64_serial #(.WIDTH(WIDTH)) u_rem (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_start    (w_start),
    .i_dividend (r_dividend),
    .i_divisor  (w_cur_cycle),
    .o_done     (w_done),
    .o_rem      (w_rem)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (SYNC_SET) w_next_state = S_LOAD;
      S_LOAD:  w_next_state = S_ITER;
      S_ITER:  if (r_iter == 7'(ITERS - 1)) w_next_state = S_STORE;
      S_STORE: w_next_state = w_last_idx ? S_IDLE : S_LOAD;
      default: w_next_state = S_IDLE;
    endcase
    if (SYNC_SET) w_next_state = S_LOAD;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_dividend <= '0;
      r_iter     <= '0;
      r_small    <= 1'b0;
      r_sys_time <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_sys_time <= SYNC_SET ? ECAT_SYNC_TIME : r_sys_time + 64'd1;
      // Busy trails the sync edge by one cycle and drops with the final store.
      r_busy     <= (r_state != S_IDLE) && !((r_state == S_STORE) && w_last_idx);
      if (SYNC_SET) begin
        r_idx      <= '0;
        r_dividend <= ECAT_SYNC_TIME + 64'(SLOT);
      end else begin
        case (r_state)
          S_LOAD: begin
            r_iter  <= '0;
            r_small <= (w_cur_cycle < WIDTH'(2));
          end
          S_ITER:  r_iter <= r_iter + 7'd1;
          S_STORE: begin
            r_dividend <= r_dividend + 64'(SLOT);
            r_idx      <= w_last_idx ? '0 : r_idx + IW'(1);
          end
          default: ;
        endcase
      end
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_cnt
    localparam logic [IW-1:0] IDX = IW'(g);
    logic [WIDTH-1:0] w_cyc;
    logic [WIDTH-1:0] r_cnt;

    assign w_cyc = CYCLE[g*WIDTH +: WIDTH];

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_cnt <= '0;
      end else if (w_store && (r_idx == IDX)) begin
        r_cnt <= r_small ? '0 : w_rem;
      end else if ((w_cyc < WIDTH'(2)) || (r_cnt >= w_cyc - WIDTH'(1))) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
    end

    assign TIME_CNT[g*WIDTH +: WIDTH] = r_cnt;
  end

  assign SYS_TIME    = r_sys_time;
  assign SYNC_BUSY   = r_busy;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_synchronizer.sv
// Directed bench for the synchronizer: table of sync vectors plus hand-written
// sequences for reset, restart, full realignment and live cycle changes.
module tb_synchronizer;
  import synchronizer_pkg::*;

  localparam int W = 13;
  localparam int D = 249;

  logic           CLK = 1'b0;
  logic           RST;
  logic [63:0]    ECAT_SYNC_TIME;
  logic           SYNC_SET;
  logic [W*D-1:0] CYCLE;
  logic [63:0]    SYS_TIME;
  logic [W*D-1:0] TIME_CNT;
  logic           SYNC_BUSY;
  logic [1:0]     o_dbg_state;

  synchronizer #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ECAT_SYNC_TIME (ECAT_SYNC_TIME),
    .SYNC_SET       (SYNC_SET),
    .CYCLE          (CYCLE),
    .SYS_TIME       (SYS_TIME),
    .TIME_CNT       (TIME_CNT),
    .SYNC_BUSY      (SYNC_BUSY),
    .o_dbg_state    (o_dbg_state)
  );

  // clock
  always #5 CLK = ~CLK;

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [63:0]   m_time  = '0;
  logic [W-1:0]  exp_q[$];

  typedef struct {
    logic [63:0] t;
    logic [W-1:0] cyc0;
    logic [63:0] exp_sys;
    logic [W-1:0] exp_cnt0;
  } vec_t;
  vec_t vecs[8];

  // One edge; the model time follows the inputs that were present at the edge.
  task automatic tick();
    logic        s;
    logic        r;
    logic [63:0] t;
    s = SYNC_SET;
    r = RST;
    t = ECAT_SYNC_TIME;
    @(posedge CLK);
    #1;
    if (r) m_time = '0;
    else if (s) m_time = t;
    else m_time = m_time + 64'd1;
  endtask

  function automatic logic [W-1:0] cnt_of(int i);
    return TIME_CNT[i*W +: W];
  endfunction

  function automatic logic [W-1:0] cyc_of(int i);
    return CYCLE[i*W +: W];
  endfunction

  function automatic logic [W-1:0] exp_cnt(int i);
    logic [W-1:0] c;
    c = cyc_of(i);
    if (c < W'(2)) return '0;
    return W'(m_time % 64'(c));
  endfunction

  task automatic set_cycle(input int i, input logic [W-1:0] v);
    CYCLE[i*W +: W] = v;
  endtask

  task automatic set_all_cycles(input logic [W-1:0] v);
    for (int i = 0; i < D; i++) set_cycle(i, v);
  endtask

  task automatic set_mixed_cycles();
    for (int i = 0; i < D; i++) set_cycle(i, W'(2000 + i));
    set_cycle(5, W'(1));
    set_cycle(6, W'(0));
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic sync(input logic [63:0] t);
    ECAT_SYNC_TIME = t;
    SYNC_SET = 1'b1;
    tick();
    SYNC_SET = 1'b0;
    ECAT_SYNC_TIME = {$urandom(), $urandom()};
  endtask

  task automatic wait_busy_fall(input int k0, output int k);
    k = k0;
    do begin
      tick();
      k++;
    end while (SYNC_BUSY !== 1'b0 && k < 17000);
  endtask

  task automatic check_zero_state(input string name);
    int bad;
    bad = -1;
    check({name, "_sys"}, SYS_TIME, 64'd0);
    check({name, "_busy"}, 64'(SYNC_BUSY), 64'd0);
    check({name, "_state"}, 64'(o_dbg_state), 64'(S_IDLE));
    for (int i = 0; i < D; i++) if (bad < 0 && cnt_of(i) !== '0) bad = i;
    n_tests++;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s_cnt: TIME_CNT[%0d] got %0d, expected 0", name, bad, cnt_of(bad));
    end
  endtask

  // Every cycle: SYS_TIME tracks the model, busy is low, each counter equals
  // model time mod its cycle.
  task automatic check_aligned(input string name, input int ncyc);
    bit    bad;
    string msg;
    bad = 1'b0;
    for (int n = 0; n < ncyc; n++) begin
      tick();
      if (!bad && SYS_TIME !== m_time) begin
        bad = 1'b1;
        msg = $sformatf("cycle %0d SYS_TIME got %0d, expected %0d", n, SYS_TIME, m_time);
      end
      if (!bad && SYNC_BUSY !== 1'b0) begin
        bad = 1'b1;
        msg = $sformatf("cycle %0d SYNC_BUSY got %0b, expected 0", n, SYNC_BUSY);
      end
      for (int i = 0; i < D; i++) begin
        if (!bad && cnt_of(i) !== exp_cnt(i)) begin
          bad = 1'b1;
          msg = $sformatf("cycle %0d TIME_CNT[%0d] got %0d, expected %0d",
                          n, i, cnt_of(i), exp_cnt(i));
        end
      end
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL %s: %s", name, msg);
    end
  endtask

  initial begin
    int k;
    int bad_seq;

    vecs[0] = '{64'd1000,                 W'(4096), 64'd1066,        W'(1066)};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFF6,  W'(4096), 64'd56,          W'(56)};
    vecs[2] = '{64'd123456,               W'(1000), 64'd123522,      W'(522)};
    vecs[3] = '{64'd7,                    W'(0),    64'd73,          W'(0)};
    vecs[4] = '{64'd99999,                W'(7),    64'd100065,      W'(0)};
    vecs[5] = '{64'hFFFF_FFFF_FFFF_FFFF,  W'(8191), 64'd65,          W'(65)};
    vecs[6] = '{64'h0000_0001_0000_0000,  W'(4095), 64'd4294967362,  W'(322)};
    vecs[7] = '{64'd1001,                 W'(2),    64'd1067,        W'(1)};

    // reset
    RST = 1'b1;
    SYNC_SET = 1'b0;
    ECAT_SYNC_TIME = '0;
    CYCLE = '0;
    set_all_cycles(W'(4096));
    tick();
    tick();
    RST = 1'b0;
    check_zero_state("reset");

    repeat (100) tick();
    check("idle100_sys", SYS_TIME, 64'd100);
    bad_seq = -1;
    for (int i = 0; i < D; i++) if (bad_seq < 0 && cnt_of(i) !== W'(100)) bad_seq = i;
    check("idle100_cnt_first_bad", 64'(bad_seq), -64'sd1);

    // full realignment from idle, T=1000
    sync(64'd1000);
    check("t0_sys_load", SYS_TIME, 64'd1000);
    check("t0_busy_low", 64'(SYNC_BUSY), 64'd0);
    check("t0_state_load", 64'(o_dbg_state), 64'(S_LOAD));
    tick();
    check("busy_rise", 64'(SYNC_BUSY), 64'd1);
    repeat (65) tick();
    check("slot0_store", 64'(cnt_of(0)), 64'd1066);
    check("slot0_sys", SYS_TIME, 64'd1066);
    wait_busy_fall(66, k);
    check("busy_fall_4096", 64'(k), 64'd16434);
    check_aligned("align_4096", 10000);

    // live cycle shrink on transducer 3
    for (int n = 0; n < 5000 && (m_time % 64'd4096) != 64'd3000; n++) tick();
    check("cnt3_at_3000", 64'(cnt_of(3)), 64'd3000);
    set_cycle(3, W'(100));
    tick();
    check("cyc_shrink_zero", 64'(cnt_of(3)), 64'd0);
    for (int v = 1; v < 100; v++) exp_q.push_back(W'(v));
    exp_q.push_back(W'(0));
    bad_seq = 0;
    while (exp_q.size() > 0) begin
      logic [W-1:0] e;
      tick();
      e = exp_q.pop_front();
      if (bad_seq == 0 && cnt_of(3) !== e) begin
        bad_seq = 1;
        $display("FAIL cyc_shrink_seq: TIME_CNT[3] got %0d, expected %0d", cnt_of(3), e);
      end
    end
    n_tests++;
    if (bad_seq != 0) n_fail++;
    set_cycle(3, W'(4096));

    // table: each sync restarts and slot 0 lands on t0+66
    for (int v = 0; v < 8; v++) begin
      set_cycle(0, vecs[v].cyc0);
      sync(vecs[v].t);
      repeat (66) tick();
      check($sformatf("vec%0d_sys", v), SYS_TIME, vecs[v].exp_sys);
      check($sformatf("vec%0d_cnt0", v), 64'(cnt_of(0)), 64'(vecs[v].exp_cnt0));
      check($sformatf("vec%0d_busy", v), 64'(SYNC_BUSY), 64'd1);
    end

    // mixed cycles across the 64-bit wrap
    set_mixed_cycles();
    sync(64'hFFFF_FFFF_FFFF_FFF6);
    wait_busy_fall(0, k);
    check("busy_fall_mixed", 64'(k), 64'd16434);
    check("mixed_sys_at_fall", SYS_TIME, 64'd16424);
    check("mixed_cnt5", 64'(cnt_of(5)), 64'd0);
    check("mixed_cnt6", 64'(cnt_of(6)), 64'd0);
    check_aligned("align_mixed", 2000);

    // second sync at t0+3000 restarts from slot 0
    sync(64'd1);
    repeat (2999) tick();
    sync(64'd5000);
    wait_busy_fall(0, k);
    check("busy_fall_restart", 64'(k), 64'd16434);
    check("restart_sys_at_fall", SYS_TIME, 64'd21434);
    check_aligned("align_restart", 500);

    // reset beats a simultaneous sync
    RST = 1'b1;
    ECAT_SYNC_TIME = 64'd999;
    SYNC_SET = 1'b1;
    tick();
    RST = 1'b0;
    SYNC_SET = 1'b0;
    check("rst_over_sync_sys", SYS_TIME, 64'd0);
    tick();
    check("rst_over_sync_busy", 64'(SYNC_BUSY), 64'd0);
    check("rst_over_sync_state", 64'(o_dbg_state), 64'(S_IDLE));

    // reset mid-realignment aborts with no later stores
    sync(64'd777);
    repeat (499) tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    check_zero_state("rst_mid");
    check_aligned("post_rst_no_store", 200);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/synchronizer.md
SYNCHRONIZER -- requirements
Module: synchronizer

Interface
REQ-001 Parameters SHALL be: WIDTH, default 13, per-transducer cycle width; DEPTH, default 249, transducer count.
REQ-002 CLK  input  1  sole clock; all logic SHALL be clocked on its rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 ECAT_SYNC_TIME  input  64  sync time in CLK ticks, valid while SYNC_SET is high.
REQ-005 SYNC_SET  input  1  single-cycle sync request from the controller.
REQ-006 CYCLE  input  WIDTH x DEPTH  per-transducer period in ticks.
REQ-007 SYS_TIME  output  64  local system time.
REQ-008 TIME_CNT  output  WIDTH x DEPTH  per-transducer phase counter.
REQ-009 SYNC_BUSY  output  1  high while phase realignment is in progress.

Function
REQ-010 SYS_TIME SHALL load ECAT_SYNC_TIME on the edge where SYNC_SET=1, otherwise increment by 1 per edge with 64-bit wrap.
REQ-011 Each TIME_CNT[i] SHALL increment per edge and go to 0 when its value is >= CYCLE[i]-1, using the live CYCLE[i].
REQ-012 CYCLE[i] < 2 SHALL hold TIME_CNT[i] at 0.
REQ-013 Realignment SHALL process transducers serially, i = 0..DEPTH-1, in fixed slots of SLOT=66 cycles each.
REQ-014 Slot i SHALL compute (T + SLOT*(i+1)) mod CYCLE[i] mod 2^64, where T is the latched ECAT_SYNC_TIME.
REQ-015 The divisor SHALL be sampled at slot start.
REQ-016 Slot i SHALL write TIME_CNT[i] on edge t0+SLOT*(i+1), where t0 is the SYNC_SET edge, so that TIME_CNT[i] equals SYS_TIME mod CYCLE[i] on that edge.
REQ-017 The slot dividend SHALL be held in a 64-bit register initialised to T+SLOT at t0 and incremented by SLOT per slot; no multiplier.
REQ-018 Remainder SHALL use a restoring shift-subtract scheme: 64 iterations, MSB first, (WIDTH+1)-bit partial remainder.
REQ-019 Slot timing: 1 cycle load, 64 cycles iterate, 1 cycle store.
REQ-020 A slot with divisor < 2 SHALL still consume SLOT cycles and store 0.
REQ-021 Transducers not yet stored SHALL keep free-running per REQ-011.
REQ-022 FSM states SHALL be IDLE, LOAD, ITER, STORE.
  - IDLE -> LOAD on SYNC_SET.
  - LOAD -> ITER.
  - ITER -> STORE after 64 iterations.
  - STORE -> LOAD while i < DEPTH-1, else -> IDLE.
REQ-023 SYNC_SET in any non-IDLE state SHALL restart from slot 0 with the new T; partially realigned counters keep running.
REQ-024 SYNC_BUSY SHALL rise on the edge after t0 and fall on edge t0+SLOT*DEPTH, concurrent with the final store.
REQ-025 The STORE write SHALL take priority over the REQ-011 increment for the same index.

Reset
REQ-026 On RST the block SHALL set SYS_TIME=0, all TIME_CNT=0, SYNC_BUSY=0, FSM=IDLE, slot index=0 and dividend=0.
REQ-027 RST SHALL dominate SYNC_SET on the same edge.
REQ-028 RST mid-realignment SHALL abort it with no partial store.

Structure
REQ-029 A shared package SHALL hold SLOT (66), the state enum and the iteration count (64).
REQ-030 WIDTH and DEPTH SHALL remain module parameters.
REQ-031 The remainder engine SHALL be one sub-module, rem64_serial: start/done handshake, 64-bit dividend, WIDTH-bit divisor, WIDTH-bit remainder, 65-cycle latency from start to done.
REQ-032 The synchronizer SHALL own the slot FSM, the counters and SYS_TIME.

Verification
REQ-033 RST, then 100 idle cycles -> SYS_TIME=100, every TIME_CNT[i] = 100 mod CYCLE[i] with CYCLE=4096.
REQ-034 SYNC_SET with T=1000, all CYCLE=4096 -> TIME_CNT[0]=1066 at t0+66; after SYNC_BUSY falls, every TIME_CNT[i]==SYS_TIME mod 4096 for 10000 cycles.
REQ-035 Mixed CYCLE (CYCLE[i]=2000+i, CYCLE[5]=1, CYCLE[6]=0), T=2^64-10 -> wrap correct; TIME_CNT[5]=TIME_CNT[6]=0; others match the SYS_TIME mod reference.
REQ-036 Second SYNC_SET (T=5000) at t0+3000 -> restart from slot 0; SYNC_BUSY falls at the new t0+16434; all counters aligned to the new time.
REQ-037 RST asserted at t0+500 -> next cycle all outputs 0, SYNC_BUSY=0, no further stores.
REQ-038 CYCLE[3] changed 4096->100 while TIME_CNT[3]=3000 -> next edge TIME_CNT[3]=0, then counts 0..99.
